inst_fetch_queue: RTL and testbench

//  Instruction fetch front end upstream of the IF2ID pipeline register.

---
 rtl/inst_fetch_queue.sv | 128 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Purpose : instruction fetch front end; owns fetch PC, issues word fetches, buffers {inst, PC+step} for decode.
// Latency : response valid in cycle N -> out_valid in cycle N+1; one fetch outstanding, 1 instr / 2 cycles with 1-cycle memory.
// Backpressure: out_ready low fills the DEPTH-entry FIFO; no request is issued unless the response has a free slot.
//
// Ports:
//    clk, rst                    clock, synchronous active-high reset
//    imem_req/addr/gnt           fetch request (addr = fetch_pc), accepted on req && gnt
//    imem_rvalid/rdata           in-order response, at most one outstanding
//    out_valid/ready/inst/pc     head of the FIFO toward IF2ID (out_pc = fetch PC + PC_STEP)
//    redirect/redirect_pc        taken branch: flush FIFO, refetch from redirect_pc
//    occupancy                   number of valid FIFO entries
module inst_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_req,
   output logic [31:0]                imem_addr,
   input  logic                       imem_gnt,
   input  logic                       imem_rvalid,
   input  logic [31:0]                imem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_inst,
   output logic [31:0]                out_pc,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   tag_pc;
   logic [31:0]   inst_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   logic fire;
   logic push;
   logic pop;
   logic outstanding;

   // Only one fetch is ever in flight and only the in-flight response can
   // push, so checking occupancy < DEPTH at request time reserves its slot.
   assign imem_req  = (state == IDLE) && (occupancy < OW'(DEPTH)) && !rst;
   assign imem_addr = fetch_pc;
   assign fire      = imem_req && imem_gnt;

   // A response that lands in the same cycle as a redirect belongs to the
   // old path and is dropped.
   assign push      = (state == WAIT) && imem_rvalid && !redirect;
   assign pop       = out_valid && out_ready;

   // A response is still owed after this cycle if one is in flight and not
   // arriving now, or if a new fetch is granted this cycle. A redirect in
   // DISCARD that coincides with the stale response therefore returns to
   // IDLE rather than waiting for a response that will never come.
   assign outstanding = (((state == WAIT) || (state == DISCARD)) && !imem_rvalid) || fire;

   assign out_valid = (occupancy != '0);
   assign out_inst  = inst_mem[rd_ptr];
   assign out_pc    = pc_mem[rd_ptr];

   // Storage array, no reset needed: entries are only visible through occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]   <= tag_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         tag_pc    <= RESET_PC;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (redirect) begin
         // Flush; a pop in this cycle has already been taken by decode.
         fetch_pc  <= redirect_pc;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         state     <= outstanding ? DISCARD : IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (fire) begin
                  fetch_pc <= fetch_pc + PC_STEP;
                  tag_pc   <= fetch_pc + PC_STEP;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) state <= IDLE;
            end
            DISCARD: begin
               if (imem_rvalid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);

         case ({push, pop})
            2'b10:   occupancy <= occupancy + OW'(1);
            2'b01:   occupancy <= occupancy - OW'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [2:0]  occupancy;

   int tests_run = 0;
   int tests_failed = 0;

   // memory model controls
   logic gnt_en = 1'b0;
   int   lat = 1;

   logic        pend = 1'b0;
   logic [31:0] paddr = '0;
   int          cnt = 0;

   // observed transfers
   logic [31:0] gnt_q[$];
   logic [31:0] pop_inst_q[$];
   logic [31:0] pop_pc_q[$];

   always #5 clk = ~clk;

   inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'd0), .PC_STEP(32'd1)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_pc      (out_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .occupancy   (occupancy)
   );

   // Instruction memory: mem[k] = 0x100 + k, response 'lat' cycles after grant.
   assign imem_gnt    = gnt_en;
   assign imem_rvalid = pend && (cnt == 0);
   assign imem_rdata  = 32'h100 + paddr;

   always @(posedge clk) begin
      if (imem_req && imem_gnt) begin
         pend  <= 1'b1;
         paddr <= imem_addr;
         cnt   <= lat - 1;
      end else if (pend) begin
         if (cnt == 0) pend <= 1'b0;
         else          cnt  <= cnt - 1;
      end
   end

   // Record grants and pops just before the posedge that completes them.
   always @(negedge clk) begin
      #2;
      if (imem_req && imem_gnt) gnt_q.push_back(imem_addr);
      if (out_valid && out_ready) begin
         pop_inst_q.push_back(out_inst);
         pop_pc_q.push_back(out_pc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_q();
      gnt_q.delete();
      pop_inst_q.delete();
      pop_pc_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = '0;
      step(4);
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b1;
      redirect = 1'b0;
      redirect_pc = '0;
      step(1);

      // ---- 1: reset state, basic streaming
      gnt_en = 1'b1; lat = 1; out_ready = 1'b1;
      do_reset();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_occ", {29'd0, occupancy}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      clear_q();
      rst = 1'b0;
      step(1);
      chk("t1_wait_valid", {31'd0, out_valid}, 32'd0);
      chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
      step(1);
      chk("t1_lat_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_lat_inst", out_inst, 32'h100);
      step(6);
      chk("t1_ngnt", gnt_q.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
      chk("t1_addr0", gnt_q[0], 32'd0);
      chk("t1_addr1", gnt_q[1], 32'd1);
      chk("t1_addr2", gnt_q[2], 32'd2);
      chk("t1_npop", pop_inst_q.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
      chk("t1_inst0", pop_inst_q[0], 32'h100);
      chk("t1_inst1", pop_inst_q[1], 32'h101);
      chk("t1_inst2", pop_inst_q[2], 32'h102);
      chk("t1_pc0", pop_pc_q[0], 32'd1);
      chk("t1_pc1", pop_pc_q[1], 32'd2);
      chk("t1_pc2", pop_pc_q[2], 32'd3);

      // ---- 2: backpressure fills FIFO
      out_ready = 1'b0;
      do_reset();
      clear_q();
      rst = 1'b0;
      step(20);
      chk("t2_ngnt", gnt_q.size(), 32'd4);
      chk("t2_req_low", {31'd0, imem_req}, 32'd0);
      chk("t2_occ_full", {29'd0, occupancy}, 32'd4);
      chk("t2_head_inst", out_inst, 32'h100);
      chk("t2_head_pc", out_pc, 32'd1);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      chk("t2_occ_pop", {29'd0, occupancy}, 32'd3);
      chk("t2_req_again", {31'd0, imem_req}, 32'd1);
      chk("t2_head2_inst", out_inst, 32'h101);
      chk("t2_head2_pc", out_pc, 32'd2);

      // ---- 3a: redirect while in WAIT, response still in flight
      out_ready = 1'b1; lat = 3;
      do_reset();
      rst = 1'b0;
      step(1);                       // fetch of addr 0 granted, now WAIT
      clear_q();
      redirect = 1'b1; redirect_pc = 32'h40;
      step(1);
      redirect = 1'b0;
      chk("t3_occ", {29'd0, occupancy}, 32'd0);
      chk("t3_valid", {31'd0, out_valid}, 32'd0);
      chk("t3_discard_req", {31'd0, imem_req}, 32'd0);
      step(14);
      chk("t3_addr0", gnt_q[0], 32'h40);
      chk("t3_inst0", pop_inst_q[0], 32'h140);
      chk("t3_pc0", pop_pc_q[0], 32'h41);

      // ---- 3b: redirect in WAIT coinciding with the response
      lat = 1;
      do_reset();
      rst = 1'b0;
      step(1);                       // WAIT, rvalid high this cycle
      chk("t3b_rvalid", {31'd0, imem_rvalid}, 32'd1);
      redirect = 1'b1; redirect_pc = 32'h20;
      step(1);
      redirect = 1'b0;
      chk("t3b_occ", {29'd0, occupancy}, 32'd0);
      chk("t3b_req", {31'd0, imem_req}, 32'd1);
      chk("t3b_addr", imem_addr, 32'h20);

      // ---- 4: redirect at occupancy 3 with a pop in the same cycle
      out_ready = 1'b0; lat = 1; gnt_en = 1'b1;
      do_reset();
      rst = 1'b0;
      for (int i = 0; i < 20 && occupancy != 3'd3; i++) step(1);
      chk("t4_occ3", {29'd0, occupancy}, 32'd3);
      gnt_en = 1'b0;
      clear_q();
      out_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 32'h80;
      step(1);
      redirect = 1'b0;
      chk("t4_pop_cnt", pop_inst_q.size(), 32'd1);
      chk("t4_pop_inst", pop_inst_q[0], 32'h100);
      chk("t4_occ0", {29'd0, occupancy}, 32'd0);
      chk("t4_valid0", {31'd0, out_valid}, 32'd0);
      gnt_en = 1'b1;
      step(10);
      chk("t4_next_inst", pop_inst_q[1], 32'h180);
      chk("t4_next_pc", pop_pc_q[1], 32'h81);

      // ---- 5: grant stall
      out_ready = 1'b1; lat = 1; gnt_en = 1'b0;
      do_reset();
      clear_q();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("t5_req_held", {31'd0, imem_req}, 32'd1);
         chk("t5_addr_held", imem_addr, 32'd0);
      end
      gnt_en = 1'b1;
      step(1);
      chk("t5_ngnt", gnt_q.size(), 32'd1);
      chk("t5_gnt_addr", gnt_q[0], 32'd0);

      // ---- 6: reset while a response is pending
      lat = 3; gnt_en = 1'b1; out_ready = 1'b1;
      do_reset();
      rst = 1'b0;
      step(1);                       // addr 0 granted, response in 3 cycles
      rst = 1'b1; gnt_en = 1'b0;
      step(1);
      rst = 1'b0;
      clear_q();
      chk("t6_addr", imem_addr, 32'd0);
      chk("t6_occ", {29'd0, occupancy}, 32'd0);
      step(4);                       // late rvalid passes while IDLE
      chk("t6_occ_late", {29'd0, occupancy}, 32'd0);
      chk("t6_valid_late", {31'd0, out_valid}, 32'd0);
      chk("t6_npop", pop_inst_q.size(), 32'd0);
      lat = 1; gnt_en = 1'b1;
      step(6);
      chk("t6_first_inst", pop_inst_q[0], 32'h100);
      chk("t6_first_pc", pop_pc_q[0], 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
